// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one decimal digit per clock, LSD first.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, sampled only in IDLE
//   sub               0 = a+b+cin, 1 = a-b-cin (latched on start)
//   a, b              packed BCD operands, digit 0 in bits [3:0]
//   cin               carry-in (add) / borrow-in (subtract)
//   sum               packed BCD result
//   cout              carry-out (add) / borrow-out (subtract)
//   invalid           a latched operand digit was greater than 9
//   busy              high while RUN or DONE
//   done              one-cycle completion pulse
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             inv_q, inv_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     sum_d;
  logic             cout_d, invalid_d, busy_d, done_d;

  // Digit datapath signals
  logic [3:0]       a_dig, b_dig, b_adj, digit;
  logic [4:0]       t;
  logic             c_next;
  logic [W-1:0]     res_ins;
  logic             inv_scan;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      inv_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      inv_q   <= inv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum     <= sum_d;
      cout    <= cout_d;
      invalid <= invalid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, digit arithmetic and registered-output values
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    sub_d     = sub_q;
    inv_d     = inv_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_d     = sum;
    cout_d    = cout;
    invalid_d = invalid;
    busy_d    = busy;
    done_d    = 1'b0;

    // Select the current digit pair
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IDX_W'(i) == idx_q) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end

    // Subtraction adds the nine's complement; the initial carry supplies the +1
    b_adj = sub_q ? 4'(4'd9 - b_dig) : b_dig;
    t     = 5'(a_dig) + 5'(b_adj) + 5'(carry_q);
    if (t > 5'd9) begin
      digit  = 4'(t + 5'd6);
      c_next = 1'b1;
    end else begin
      digit  = t[3:0];
      c_next = 1'b0;
    end

    res_ins = res_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IDX_W'(i) == idx_q) res_ins[4*i +: 4] = digit;
    end

    // Any non-BCD digit in the incoming operands
    inv_scan = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) inv_scan = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub ? ~cin : cin;
          inv_d   = inv_scan;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        res_d   = res_ins;
        carry_d = c_next;
        if (idx_q == LAST_IDX) begin
          state_d   = S_DONE;
          sum_d     = res_ins;
          cout_d    = sub_q ? ~c_next : c_next;
          invalid_d = inv_q;
          done_d    = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised multi-digit BCD adder/subtractor. It processes one decimal digit per clock cycle, least-significant digit first, under a start/busy/done handshake. It extends the single-digit combinational BCD adder lab block to N digits, adds a subtract mode and input-digit validation, and sits between the digit-entry registers and the 7-segment display driver.

## Interface
- DIGITS, default 4: number of BCD digits per operand (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A−B−cin. Latched on accepted start.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- cin  input  1  carry-in for add, borrow-in for subtract.
- sum  output  4*DIGITS  packed BCD result.
- cout  output  1  carry-out for add, borrow-out for subtract.
- invalid  output  1  a latched operand digit was greater than 9.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.

## Operation
- **Reset:** state=IDLE. sum, cout, invalid, busy and done are all 0. Internal index and carry are 0. Reset has immediate effect in any state. An operation in progress is discarded with no done pulse.
- **States:**
  - IDLE→RUN on a clock edge with start=1.
  - RUN→RUN while idx<DIGITS−1, then RUN→DONE.
  - DONE→IDLE unconditionally.
- **Start accepted (IDLE edge with start=1):**
  - Latch a, b and sub. Set idx=0.
  - Initial carry c = cin for add, ~cin for sub.
  - invalid_int = OR over all digits of a and b of (digit>9).
- **Per RUN edge, digit i = idx:**
  - b' = b_i for add; b' = 9−b_i for sub (nine's complement, 4-bit wrap).
  - t = a_i + b' + c, computed 5 bits wide, maximum value 19.
  - If t>9: digit = (t+6)[3:0], c=1. Otherwise digit = t[3:0], c=0.
  - The digit is written into an internal result register at position i. Then idx increments.
- **RUN→DONE edge:**
  - sum ← internal result.
  - cout ← c for add, ~c for sub.
  - invalid ← invalid_int.
- **Subtract result:** if borrow-out is 1, sum is the ten's complement of the magnitude, i.e. (A−B−cin) mod 10^DIGITS.
- **Invalid input:** the computation still runs the full DIGITS cycles. sum and cout are don't-care, but invalid=1 is mandatory.
- **Output stability:** start during RUN or DONE is ignored and not queued. The sum, cout and invalid outputs change only on the RUN→DONE edge, and otherwise hold the previous result.
- **Operand stability:** a and b may change freely after the accepting edge.

## Timing
- Accepting edge E0. RUN occupies edges E1..E(DIGITS), one digit per edge.
- done=1 and the new sum, cout and invalid are visible in the cycle after edge E(DIGITS). So the latency from start sample to done is DIGITS+1 cycles. With DIGITS=4, done is high 5 cycles after the start edge.
- busy rises after E0 and falls after the DONE cycle. busy is high for DIGITS+1 cycles.
- Back-to-back operation: start held high through DONE is accepted on the first IDLE edge. The minimum period is therefore DIGITS+2 cycles.
- done, busy and all outputs are registered, with no combinational path from inputs.

## Test plan
- **Basic add:** DIGITS=4, a=0x0042, b=0x0026, sub=0, cin=0, start pulse → done after 5 cycles, sum=0x0068, cout=0, invalid=0. Repeat with cin=1 → sum=0x0069.
- **Carry ripple:** a=0x0055, b=0x0056, cin=1 → sum=0x0112, cout=0. Then a=0x9997, b=0x0007, cin=0 → sum=0x0004, cout=1. Then a=0x0009, b=0x0007, cin=1 → sum=0x0017.
- **Subtract:** sub=1, a=0x0100, b=0x0001, cin=0 → sum=0x0099, cout=0. Then a=0x0001, b=0x0002, cin=0 → sum=0x9999, cout=1 (borrow). Then a=0x0005, b=0x0005, cin=1 → sum=0x9999, cout=1.
- **Invalid input:** a=0x00A3, b=0x0001 → done after 5 cycles with invalid=1. A following valid add clears invalid to 0.
- **Handshake:**
  - A second start pulse during RUN is ignored: exactly one done pulse occurs, and sum is unchanged by the second pulse's operands.
  - start held high for 20 cycles → a done pulse every 6 cycles.
- **Reset mid-operation:** assert rst_n=0 two cycles after start. Outputs go to 0 immediately (asynchronously) and no done pulse follows. After release, a fresh 0x0042+0x0026 add gives 0x0068.
